tm_stream_loader: RTL and testbench
===================================

Name: tm_stream_loader

Overview:
- Host-side front end for the Tsetlin Machine inference core; the transmit end of the core's features/exclude-mask input interface.
- Receives a byte stream of command frames and assembles clause exclude masks and feature vectors into registers that drive the core.
- Waits the core's fixed latency, samples the class, and returns it as a response byte.

Parameters:
- NUM_FEAT, 9: features per sample; each clause mask is LIT_W = 2*NUM_FEAT bits wide.
- NUM_CLAUSES, 12: number of clause exclude masks.
- CLASS_W, 2: width of the class result, at most 7.
- INFER_LAT, 2: cycles from feat/ex update to a valid class_in, at least 1.

Ports:
- clk1  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  8  command stream byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  loader accepts the byte.
- out_data  out  8  response byte.
- out_valid  out  1  response valid.
- out_ready  in  1  host accepts the response.
- features  out  NUM_FEAT  feature vector to the core.
- ex_flat  out  NUM_CLAUSES*LIT_W  exclude masks; clause k occupies bits [k*LIT_W +: LIT_W].
- class_in  in  CLASS_W  class from the core.
- model_valid  out  1  a complete model has been committed.
- err  out  1  one-cycle pulse on a bad opcode or a rejected frame.

Behaviour:
- Interface: one clock (clk1). Reset is asynchronous and active-low (rst_n).
- Reset values: features=0, ex_flat=0, shadow=0, model_valid=0, out_valid=0, out_data=0, err=0, in_ready=1, state=IDLE.
- A byte transfers when in_valid && in_ready. An out_data transfer completes when out_valid && out_ready.
- BPC = ceil(LIT_W/8) bytes per clause (3 at defaults). BPF = ceil(NUM_FEAT/8) bytes per feature vector (2 at defaults).
- Multi-byte words are little-endian. Bits above the field width are ignored.
- FSM states: IDLE, LOAD_EX, LOAD_FEAT, WAIT, RESP.
- IDLE, per opcode byte:
  - 0xA5: go to LOAD_EX and clear the byte/clause counters.
  - 0x5A: go to LOAD_FEAT.
  - Any other value: err pulse; stay in IDLE.
- LOAD_EX:
  - Accept NUM_CLAUSES*BPC bytes into the shadow mask registers, clause 0 first.
  - On the last byte, the shadow is copied to ex_flat on the next edge, model_valid is set to 1, and the state returns to IDLE.
  - ex_flat never changes mid-frame.
- LOAD_FEAT:
  - Accept BPF bytes into a feature shadow.
  - On the last byte, copy it to features, load the wait counter with INFER_LAT, and go to WAIT.
- WAIT:
  - in_ready=0.
  - Decrement the counter each cycle. At 0, capture class_in into out_data and go to RESP.
  - out_data = {(8-CLASS_W)'b0, class_in}.
  - If model_valid=0, out_data = 8'hFF instead.
- RESP:
  - in_ready=0 and out_valid=1.
  - out_data is held stable until out_ready. On the handshake cycle, out_valid drops and the state returns to IDLE.
- in_ready=1 only in IDLE, LOAD_EX and LOAD_FEAT.
- A new 0xA5 frame overwrites only the shadow until it completes. The live ex_flat stays valid, and model_valid stays 1, throughout.
- Reset asserted mid-frame discards the partial frame and clears all state to the reset values.
- Counters wrap only through an explicit reset to 0 on frame completion; no other counter wrap-around occurs.

Optional Feature:
- Macro: TM_LOAD_CHECKSUM_EN.
- With the macro defined:
  - A 0xA5 frame carries one extra trailing byte equal to the XOR of all its mask bytes.
  - On a match, commit as above.
  - On a mismatch, ex_flat and model_valid are unchanged, err pulses for one cycle, and the state returns to IDLE.
- Without the macro: there is no checksum byte, and a frame commits on its last mask byte.

Test Plan:
- Reset, then send 0x5A 0x0F 0x01 -> after INFER_LAT+1 cycles, out_valid=1 and out_data=0xFF; features=9'h10F; model_valid=0.
- Send 0xA5 followed by 36 bytes, with clause k's bytes = {k, 0x00, 0x00} -> model_valid=1 one cycle after the last byte; ex_flat[k*18 +: 18]=k for all k; ex_flat unchanged before the last byte.
- With a model loaded and class_in tied to 2'b10, send 0x5A 0xFF 0x01 -> out_data=0x02; out_ready held low for 5 cycles -> out_valid and out_data stable, in_ready=0; handshake -> IDLE.
- Send opcode 0x33 -> err high for exactly 1 cycle; next 0x5A frame processed normally.
- After 20 bytes of a 0xA5 frame, pulse rst_n low -> all outputs at reset values immediately; a fresh full frame loads correctly.
- TM_LOAD_CHECKSUM_EN: a full frame with a wrong checksum -> err pulse and ex_flat keeps its prior value; a correct checksum -> commit.

Source files
------------

// File: rtl/tm_stream_loader.sv
// Byte-stream front end for the Tsetlin Machine core: loads exclude masks and feature vectors,
// waits the core latency and returns the class byte. Optional feature macro: TM_LOAD_CHECKSUM_EN.
module tm_stream_loader #(
  parameter int unsigned NUM_FEAT    = 9,
  parameter int unsigned NUM_CLAUSES = 12,
  parameter int unsigned CLASS_W     = 2,
  parameter int unsigned INFER_LAT   = 2
) (
  input  logic                                clk1,
  input  logic                                rst_n,
  input  logic [7:0]                          in_data,
  input  logic                                in_valid,
  output logic                                in_ready,
  output logic [7:0]                          out_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [NUM_FEAT-1:0]                 features,
  output logic [NUM_CLAUSES*2*NUM_FEAT-1:0]   ex_flat,
  input  logic [CLASS_W-1:0]                  class_in,
  output logic                                model_valid,
  output logic                                err
);

  localparam int unsigned LIT_W  = 2 * NUM_FEAT;
  localparam int unsigned BPC    = (LIT_W + 7) / 8;
  localparam int unsigned BPF    = (NUM_FEAT + 7) / 8;
  localparam int unsigned CLW    = (NUM_CLAUSES > 1) ? $clog2(NUM_CLAUSES) : 1;
  localparam int unsigned BYW    = (BPC > 1) ? $clog2(BPC) : 1;
  localparam int unsigned BFW    = (BPF > 1) ? $clog2(BPF) : 1;
  localparam int unsigned CNTW   = $clog2(INFER_LAT + 1);
  localparam int unsigned SH_W   = NUM_CLAUSES * BPC * 8;
  localparam int unsigned FSH_W  = BPF * 8;

  localparam logic [7:0] OpLoadEx   = 8'hA5;
  localparam logic [7:0] OpLoadFeat = 8'h5A;

  typedef enum logic [2:0] {
    StIdle,
    StLoadEx,
    StLoadFeat,
    StWait,
    StResp
  } state_e;

  state_e                      state_q, state_d;
  logic [CLW-1:0]              clause_q, clause_d;
  logic [BYW-1:0]              byte_q, byte_d;
  logic [BFW-1:0]              fbyte_q, fbyte_d;
  logic [SH_W-1:0]             shadow_q, shadow_d;
  logic [FSH_W-1:0]            feat_sh_q, feat_sh_d;
  logic [NUM_FEAT-1:0]         features_q, features_d;
  logic [NUM_CLAUSES*LIT_W-1:0] ex_q, ex_d;
  logic                        model_valid_q, model_valid_d;
  logic [7:0]                  out_data_q, out_data_d;
  logic                        out_valid_q, out_valid_d;
  logic                        err_q, err_d;
  logic [CNTW-1:0]             cnt_q, cnt_d;
  logic                        in_fire;
  logic                        mask_wr;
  logic                        commit;
`ifdef TM_LOAD_CHECKSUM_EN
  logic                        chk_q, chk_d;
  logic [7:0]                  xor_q, xor_d;
`endif

  always_comb begin
    in_ready = (state_q == StIdle) || (state_q == StLoadEx) || (state_q == StLoadFeat);
  end

  assign in_fire = in_valid && in_ready;

  always_comb begin
    state_d       = state_q;
    clause_d      = clause_q;
    byte_d        = byte_q;
    fbyte_d       = fbyte_q;
    shadow_d      = shadow_q;
    feat_sh_d     = feat_sh_q;
    features_d    = features_q;
    ex_d          = ex_q;
    model_valid_d = model_valid_q;
    out_data_d    = out_data_q;
    out_valid_d   = out_valid_q;
    err_d         = 1'b0;
    cnt_d         = cnt_q;
    mask_wr       = 1'b0;
    commit        = 1'b0;
`ifdef TM_LOAD_CHECKSUM_EN
    chk_d         = chk_q;
    xor_d         = xor_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (in_fire) begin
          if (in_data == OpLoadEx) begin
            state_d  = StLoadEx;
            clause_d = '0;
            byte_d   = '0;
`ifdef TM_LOAD_CHECKSUM_EN
            chk_d    = 1'b0;
            xor_d    = 8'h00;
`endif
          end else if (in_data == OpLoadFeat) begin
            state_d = StLoadFeat;
            fbyte_d = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StLoadEx: begin
        if (in_fire) begin
`ifdef TM_LOAD_CHECKSUM_EN
          if (chk_q) begin
            // Trailing byte: commit only if it matches the running XOR of mask bytes.
            chk_d   = 1'b0;
            state_d = StIdle;
            if (in_data == xor_q) begin
              commit = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end else begin
            mask_wr = 1'b1;
          end
`else
          mask_wr = 1'b1;
`endif
        end
      end
      StLoadFeat: begin
        if (in_fire) begin
          feat_sh_d[int'(fbyte_q)*8 +: 8] = in_data;
          if (fbyte_q == BFW'(BPF - 1)) begin
            features_d = feat_sh_d[NUM_FEAT-1:0];
            cnt_d      = CNTW'(INFER_LAT);
            fbyte_d    = '0;
            state_d    = StWait;
          end else begin
            fbyte_d = fbyte_q + 1'b1;
          end
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          out_data_d  = model_valid_q ? 8'(class_in) : 8'hFF;
          out_valid_d = 1'b1;
          state_d     = StResp;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StResp: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (mask_wr) begin
      shadow_d[int'(clause_q)*BPC*8 + int'(byte_q)*8 +: 8] = in_data;
`ifdef TM_LOAD_CHECKSUM_EN
      xor_d = xor_q ^ in_data;
`endif
      if (byte_q == BYW'(BPC - 1)) begin
        byte_d = '0;
        if (clause_q == CLW'(NUM_CLAUSES - 1)) begin
          clause_d = '0;
`ifdef TM_LOAD_CHECKSUM_EN
          chk_d    = 1'b1;
`else
          commit   = 1'b1;
          state_d  = StIdle;
`endif
        end else begin
          clause_d = clause_q + 1'b1;
        end
      end else begin
        byte_d = byte_q + 1'b1;
      end
    end

    // Padding bits above LIT_W in each clause's byte group are dropped here.
    if (commit) begin
      for (int k = 0; k < int'(NUM_CLAUSES); k++) begin
        ex_d[k*LIT_W +: LIT_W] = shadow_d[k*BPC*8 +: LIT_W];
      end
      model_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      clause_q      <= '0;
      byte_q        <= '0;
      fbyte_q       <= '0;
      shadow_q      <= '0;
      feat_sh_q     <= '0;
      features_q    <= '0;
      ex_q          <= '0;
      model_valid_q <= 1'b0;
      out_data_q    <= 8'h00;
      out_valid_q   <= 1'b0;
      err_q         <= 1'b0;
      cnt_q         <= '0;
`ifdef TM_LOAD_CHECKSUM_EN
      chk_q         <= 1'b0;
      xor_q         <= 8'h00;
`endif
    end else begin
      state_q       <= state_d;
      clause_q      <= clause_d;
      byte_q        <= byte_d;
      fbyte_q       <= fbyte_d;
      shadow_q      <= shadow_d;
      feat_sh_q     <= feat_sh_d;
      features_q    <= features_d;
      ex_q          <= ex_d;
      model_valid_q <= model_valid_d;
      out_data_q    <= out_data_d;
      out_valid_q   <= out_valid_d;
      err_q         <= err_d;
      cnt_q         <= cnt_d;
`ifdef TM_LOAD_CHECKSUM_EN
      chk_q         <= chk_d;
      xor_q         <= xor_d;
`endif
    end
  end

  assign features    = features_q;
  assign ex_flat     = ex_q;
  assign model_valid = model_valid_q;
  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign err         = err_q;

endmodule

// File: tb/tb_tm_stream_loader.sv
// Directed bench for tm_stream_loader with a response scoreboard; honours TM_LOAD_CHECKSUM_EN.
module tb_tm_stream_loader;

  localparam int NF  = 9;
  localparam int NC  = 12;
  localparam int CW  = 2;
  localparam int LAT = 2;
  localparam int LW  = 2 * NF;
  localparam int BPC = (LW + 7) / 8;
  localparam int NB  = NC * BPC;

  logic              clk1 = 1'b0;
  logic              rst_n = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [7:0]        out_data;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [NF-1:0]     features;
  logic [NC*LW-1:0]  ex_flat;
  logic [CW-1:0]     class_in = 2'b10;
  logic              model_valid;
  logic              err;

  int                checks = 0;
  int                errors = 0;
  logic [7:0]        exp_q[$];
  logic [NC*LW-1:0]  live_ex = '0;
  bit                mv = 1'b0;

  tm_stream_loader #(
    .NUM_FEAT   (NF),
    .NUM_CLAUSES(NC),
    .CLASS_W    (CW),
    .INFER_LAT  (LAT)
  ) dut (
    .clk1       (clk1),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .features   (features),
    .ex_flat    (ex_flat),
    .class_in   (class_in),
    .model_valid(model_valid),
    .err        (err)
  );

  always #5 clk1 = ~clk1;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] byte_of(input int pat, input int k, input int j);
    case (pat)
      0:       return (j == 0) ? 8'(k) : 8'h00;
      1:       return (j == 0) ? 8'(k * 5 + 1) : (j == 1) ? 8'(k) : 8'hFF;
      default: return (j == 0) ? (8'hC3 ^ 8'(k)) : (j == 1) ? 8'(k << 4) : 8'(k);
    endcase
  endfunction

  function automatic logic [LW-1:0] clause_of(input int pat, input int k);
    logic [23:0] w;
    w = {byte_of(pat, k, 2), byte_of(pat, k, 1), byte_of(pat, k, 0)};
    return w[LW-1:0];
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk1); #1;
      n++;
    end
    if (n == 100) check("in_ready_timeout", in_ready, 1'b1);
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clk1); #1;
    in_valid = 1'b0;
  endtask

  task automatic feat_frame(input string tag, input logic [NF-1:0] f);
    logic [15:0] w;
    w = 16'(f);
    send_byte(8'h5A);
    send_byte(w[7:0]);
    exp_q.push_back(mv ? 8'(class_in) : 8'hFF);
    send_byte(w[15:8]);
    check({tag, "_features"}, features, f);
    check({tag, "_in_ready_wait"}, in_ready, 1'b0);
  endtask

  task automatic get_resp(input string tag, input int hold);
    int n = 0;
    logic [7:0] e;
    while (!out_valid && n < 50) begin
      @(posedge clk1); #1;
      n++;
    end
    check({tag, "_valid"}, out_valid, 1'b1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
    check({tag, "_data"}, out_data, e);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk1); #1;
      check({tag, "_hold_valid"}, out_valid, 1'b1);
      check({tag, "_hold_data"}, out_data, e);
      check({tag, "_hold_in_ready"}, in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk1); #1;
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, out_valid, 1'b0);
    check({tag, "_idle_in_ready"}, in_ready, 1'b1);
  endtask

  task automatic ex_frame(input string tag, input int pat, input bit bad);
    logic [NC*LW-1:0] e;
    logic [7:0]       x;
    logic [7:0]       b;
    x = 8'h00;
    for (int k = 0; k < NC; k++) e[k*LW +: LW] = clause_of(pat, k);
    send_byte(8'hA5);
    for (int i = 0; i < NB; i++) begin
      b = byte_of(pat, i / BPC, i % BPC);
      x ^= b;
      send_byte(b);
      if (i == NB / 2 || i == NB - 2) check({tag, "_ex_hold"}, ex_flat, live_ex);
    end
`ifdef TM_LOAD_CHECKSUM_EN
    check({tag, "_ex_hold_pre_ck"}, ex_flat, live_ex);
    send_byte(bad ? (x ^ 8'h01) : x);
`endif
    if (!bad) begin
      live_ex = e;
      mv      = 1'b1;
    end
    check({tag, "_err"}, err, bad);
    check({tag, "_ex_flat"}, ex_flat, live_ex);
    check({tag, "_model_valid"}, model_valid, mv);
    @(posedge clk1); #1;
    check({tag, "_err_clear"}, err, 1'b0);
  endtask

  initial begin
    #3;
    check("rst_features", features, '0);
    check("rst_ex_flat", ex_flat, '0);
    check("rst_model_valid", model_valid, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 8'h00);
    check("rst_err", err, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    @(negedge clk1);
    rst_n = 1'b1;
    @(posedge clk1); #1;

    // No model yet: response must be 0xFF exactly INFER_LAT+1 cycles after the last byte.
    feat_frame("t1", 9'h10F);
    for (int i = 0; i < LAT; i++) begin
      @(posedge clk1); #1;
      check("t1_lat_no_valid", out_valid, 1'b0);
      check("t1_lat_in_ready", in_ready, 1'b0);
    end
    @(posedge clk1); #1;
    check("t1_lat_valid", out_valid, 1'b1);
    check("t1_model_valid", model_valid, 1'b0);
    get_resp("t1", 0);

    ex_frame("t2", 0, 1'b0);

    feat_frame("t3", 9'h1FF);
    get_resp("t3", 5);

    send_byte(8'h33);
    check("t4_err_pulse", err, 1'b1);
    @(posedge clk1); #1;
    check("t4_err_one_cycle", err, 1'b0);
    check("t4_in_ready", in_ready, 1'b1);
    feat_frame("t4", 9'h003);
    get_resp("t4", 0);

    // Abort a mask frame with reset partway through.
    send_byte(8'hA5);
    for (int i = 0; i < 20; i++) send_byte(byte_of(1, i / BPC, i % BPC));
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_features", features, '0);
    check("t5_rst_ex_flat", ex_flat, '0);
    check("t5_rst_model_valid", model_valid, 1'b0);
    check("t5_rst_out_valid", out_valid, 1'b0);
    check("t5_rst_out_data", out_data, 8'h00);
    check("t5_rst_in_ready", in_ready, 1'b1);
    live_ex = '0;
    mv      = 1'b0;
    @(negedge clk1);
    rst_n = 1'b1;
    @(posedge clk1); #1;
    ex_frame("t5", 1, 1'b0);
    feat_frame("t5", 9'h0AA);
    get_resp("t5", 1);

`ifdef TM_LOAD_CHECKSUM_EN
    ex_frame("t6_bad", 2, 1'b1);
    ex_frame("t6_good", 2, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
